// File: rtl/ldpc_3gpp_enc_mm_acc.sv
// Row accumulator behind the LDPC encoder matrix multiplier: XOR-accumulates the
// shifted Zc-bit column blocks of one Hb row and emits the row sum with the last column.
module ldpc_3gpp_enc_mm_acc #(
  parameter int pADDR_W = 8,
  parameter int pDAT_W  = 8
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              ival,
  input  logic              isof,
  input  logic              isop,
  input  logic              ieop,
  input  logic              ieof,
  input  logic [pDAT_W-1:0] idat,
  output logic              oval,
  output logic              osop,
  output logic              oeop,
  output logic [pDAT_W-1:0] odat,
  output logic              oerr
);

  typedef logic [pDAT_W-1:0]  dat_t;
  typedef logic [pADDR_W-1:0] addr_t;

  localparam int cWORDS = 2**pADDR_W;

  dat_t  ram [cWORDS];
  dat_t  ram_rd_reg;

  addr_t waddr_reg;
  addr_t raddr_pred_reg;
  addr_t prev_addr_reg;
  logic  prev_val_reg;
  dat_t  acc_reg;
  logic  row_open_reg;
  logic  sof_blk_reg;

  addr_t waddr_cur;
  addr_t raddr;
  logic  sof_eff;
  dat_t  rd;
  dat_t  acc;
  logic  err_now;

  always_comb begin
    waddr_cur = isop ? '0 : waddr_reg;
    // a column block opening while no row is open is treated as the first column
    sof_eff   = isop ? (isof | ~row_open_reg) : sof_blk_reg;
    rd        = (prev_val_reg && (prev_addr_reg == waddr_cur)) ? acc_reg : ram_rd_reg;
    acc       = sof_eff ? idat : (rd ^ idat);
    // pre-address the RAM with the address the next word will use
    raddr     = raddr_pred_reg;
    if (ival) begin
      raddr = ieop ? addr_t'(0) : addr_t'(waddr_cur + 1'b1);
    end
    err_now = 1'b0;
    if (ival) begin
      if (isop && !isof && !row_open_reg) err_now = 1'b1;
      if (isop && isof && row_open_reg)   err_now = 1'b1;
      if (!isop && (waddr_reg == '0))     err_now = 1'b1;
    end
  end

  // row buffer: write-first is not needed, same-address reuse goes through acc_reg
  always_ff @(posedge iclk) begin
    if (iclkena) begin
      if (ival) begin
        ram[waddr_cur] <= acc;
      end
      ram_rd_reg <= ram[raddr];
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      waddr_reg      <= '0;
      raddr_pred_reg <= '0;
      prev_addr_reg  <= '0;
      prev_val_reg   <= 1'b0;
      acc_reg        <= '0;
      row_open_reg   <= 1'b0;
      sof_blk_reg    <= 1'b0;
      oval           <= 1'b0;
      osop           <= 1'b0;
      oeop           <= 1'b0;
      odat           <= '0;
      oerr           <= 1'b0;
    end else if (iclkena) begin
      oval <= ival & ieof;
      osop <= ival & ieof & isop;
      oeop <= ival & ieof & ieop;
      if (ival) begin
        waddr_reg      <= addr_t'(waddr_cur + 1'b1);
        raddr_pred_reg <= raddr;
        prev_addr_reg  <= waddr_cur;
        prev_val_reg   <= 1'b1;
        acc_reg        <= acc;
        if (isop) begin
          sof_blk_reg <= sof_eff;
        end
        if (ieof) begin
          odat <= acc;
        end
        if (ieop) begin
          if (ieof) begin
            row_open_reg <= 1'b0;
          end else if (sof_eff) begin
            row_open_reg <= 1'b1;
          end
        end
        if (err_now) begin
          oerr <= 1'b1;
        end
      end
    end
  end

endmodule
